// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, START/BUSY/DONE
// handshake, unsigned or two's-complement operands selected by TC.
module div_seq #(
    parameter int A_width = 16,
    parameter int B_width = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [A_width-1:0] A,
    input  logic [B_width-1:0] B,
    input  logic               TC,
    output logic               BUSY,
    output logic               DONE,
    output logic [A_width-1:0] QUOTIENT,
    output logic [B_width-1:0] REMAINDER,
    output logic               DIV_BY_ZERO
);

    localparam int CW = $clog2(A_width + 1);
    localparam logic [CW-1:0] LAST = CW'(A_width - 1);

    typedef enum logic [1:0] {IDLE, CALC, POST} state_t;

    state_t state, state_next;

    logic               sign_a, sign_b, zero;
    logic [A_width-1:0] dvd;
    logic [B_width-1:0] rem, mag_b, a_low;
    logic [CW-1:0]      count;

    logic [A_width-1:0] a_mag;
    logic [B_width-1:0] b_mag;
    logic [B_width:0]   shifted, trial;
    logic [A_width-1:0] q_final;
    logic [B_width-1:0] r_final;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = CALC;
            CALC:    if (count == LAST) state_next = POST;
            POST:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign handling works on magnitudes; the most-negative value's magnitude fits unsigned.
    always_comb begin
        a_mag   = (A[A_width-1] & TC) ? -A : A;
        b_mag   = (B[B_width-1] & TC) ? -B : B;
        shifted = {rem, dvd[A_width-1]};
        trial   = shifted - {1'b0, mag_b};
        if (zero) begin
            q_final = '1;
            r_final = a_low;
        end else begin
            q_final = (sign_a ^ sign_b) ? -dvd : dvd;
            r_final = sign_a ? -rem : rem;
        end
    end

    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            zero        <= 1'b0;
            dvd         <= '0;
            rem         <= '0;
            mag_b       <= '0;
            a_low       <= '0;
            count       <= '0;
            DONE        <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        sign_a <= A[A_width-1] & TC;
                        sign_b <= B[B_width-1] & TC;
                        dvd    <= a_mag;
                        mag_b  <= b_mag;
                        rem    <= '0;
                        count  <= '0;
                        zero   <= (B == '0);
                        a_low  <= A[B_width-1:0];
                    end
                end
                CALC: begin
                    // The dividend register fills with quotient bits from the right as it shifts out.
                    if (!trial[B_width]) begin
                        rem <= trial[B_width-1:0];
                        dvd <= {dvd[A_width-2:0], 1'b1};
                    end else begin
                        rem <= shifted[B_width-1:0];
                        dvd <= {dvd[A_width-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                end
                POST: begin
                    QUOTIENT    <= q_final;
                    REMAINDER   <= r_final;
                    DIV_BY_ZERO <= zero;
                    DONE        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
